// File: rtl/trap_sched_pkg.sv
// Shared types for the trap/return sequencer: interrupt codes, FSM states,
// the captured-event record and the redirect target helper.
package trap_sched_pkg;

  localparam logic [3:0] interrupt_mach_extern = 4'd11;
  localparam logic [3:0] interrupt_mach_timer  = 4'd7;
  localparam logic [3:0] interrupt_mach_soft   = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_EXC  = 2'd1,
    KIND_IRQ  = 2'd2,
    KIND_RET  = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
  } evt_t;

  // Only interrupts vector; the base add wraps inside the 30-bit word field.
  function automatic logic [31:0] trap_target(input evt_t e, input logic [31:0] mtvec,
                                              input logic [31:0] mepc);
    logic [29:0] base;
    base = mtvec[31:2];
    if (e.kind == KIND_RET) return mepc;
    if (e.kind == KIND_IRQ && mtvec[1:0] == 2'b01) base = base + {26'b0, e.cause[3:0]};
    return {base, 2'b00};
  endfunction

endpackage

// File: rtl/trap_sched_if.sv
// Flush plus ready/valid redirect channel from the trap sequencer to fetch.
interface trap_sched_if;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (output flush, output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input flush, input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_sched_prio.sv
// Combinational event priority: exception > interrupt (meip > mtip > msip) > mret.
module trap_prio
  import trap_sched_pkg::*;
(
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic        irq_ok,
  input  logic [2:0]  irq_pend,
  input  logic        mret_req,
  output kind_e       kind,
  output logic [31:0] cause
);

  always_comb begin
    kind  = KIND_NONE;
    cause = '0;
    if (exc_valid) begin
      kind  = KIND_EXC;
      cause = {28'b0, exc_cause};
    end else if (irq_ok && |irq_pend) begin
      kind  = KIND_IRQ;
      cause = {1'b1, 27'b0, irq_pend[2] ? interrupt_mach_extern :
                            irq_pend[1] ? interrupt_mach_timer : interrupt_mach_soft};
    end else if (mret_req) begin
      kind = KIND_RET;
    end
  end

endmodule

// File: rtl/trap_sched.sv
// Trap/return sequencer: capture in IDLE, drain memory, pulse the CSR commit,
// then hold a redirect to fetch until accepted.
module trap_sched
  import trap_sched_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_tval,
  input  logic        instr_valid,
  input  logic [31:0] instr_pc,
  input  logic        mret_req,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie_en,
  input  logic [2:0]  mip_pend,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mem_busy,
  output logic        trap_en,
  output logic        mret_en,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_tval,
  output logic        drain_timeout,
  trap_sched_if.master rif
);

  state_e             state_q, state_d;
  evt_t               evt_q, evt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trap_en_q, trap_en_d;
  logic               mret_en_q, mret_en_d;
  logic               flush_q, flush_d;
  logic               rv_q, rv_d;
  logic [31:0]        rpc_q, rpc_d;
  logic               dto_q, dto_d;

  kind_e              pkind;
  logic [31:0]        pcause;

  trap_prio u_prio (
    .exc_valid (exc_valid),
    .exc_cause (exc_cause),
    .irq_ok    (mstatus_mie & instr_valid),
    .irq_pend  (mie_en & mip_pend),
    .mret_req  (mret_req),
    .kind      (pkind),
    .cause     (pcause)
  );

  always_comb begin
    state_d   = state_q;
    evt_d     = evt_q;
    cnt_d     = cnt_q;
    trap_en_d = 1'b0;
    mret_en_d = 1'b0;
    flush_d   = flush_q;
    rv_d      = rv_q;
    rpc_d     = rpc_q;
    dto_d     = dto_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pkind != KIND_NONE) begin
          // A return leaves the trap_* CSR values from the last trap untouched.
          evt_d.kind = pkind;
          if (pkind != KIND_RET) begin
            evt_d.cause = pcause;
            evt_d.epc   = (pkind == KIND_IRQ) ? instr_pc : exc_epc;
            evt_d.tval  = (pkind == KIND_EXC) ? exc_tval : '0;
          end
          state_d = ST_DRAIN;
          flush_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy || cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
          state_d   = ST_COMMIT;
          cnt_d     = '0;
          dto_d     = dto_q | mem_busy;
          trap_en_d = (evt_q.kind != KIND_RET);
          mret_en_d = (evt_q.kind == KIND_RET);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        rpc_d   = trap_target(evt_q, mtvec, mepc);
        rv_d    = 1'b1;
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (rif.redirect_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
          flush_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      evt_q     <= '0;
      cnt_q     <= '0;
      trap_en_q <= 1'b0;
      mret_en_q <= 1'b0;
      flush_q   <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      dto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      evt_q     <= evt_d;
      cnt_q     <= cnt_d;
      trap_en_q <= trap_en_d;
      mret_en_q <= mret_en_d;
      flush_q   <= flush_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
      dto_q     <= dto_d;
    end
  end

  assign trap_en            = trap_en_q;
  assign mret_en            = mret_en_q;
  assign trap_cause         = evt_q.cause;
  assign trap_epc           = evt_q.epc;
  assign trap_tval          = evt_q.tval;
  assign drain_timeout      = dto_q;
  assign rif.flush          = flush_q;
  assign rif.redirect_valid = rv_q;
  assign rif.redirect_pc    = rpc_q;

endmodule
